// File: rtl/csel_add_arbiter.sv
// rtl/csel_add_arbiter.sv - two-requester round-robin front end for a shared 2-bit carry-select adder slice
// One WIDTH-bit add per transaction, sequenced over WIDTH/2 cycles with a registered ripple carry.
module csel_add_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id
);

   localparam int NSLICE = WIDTH / 2;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rst_seen_q;

   logic             grant;
   logic             accept_en;
   logic [CW:0]      idx;
   logic [1:0]       sa, sb;
   logic             s0, c0, s1, sc;

   always_comb begin
      // Tie goes to the requester that did not win last time.
      grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
      accept_en  = (state_q == IDLE) && !rst_seen_q;
      req0_ready = accept_en && req0_valid && !grant;
      req1_ready = accept_en && req1_valid && grant;

      idx = {cnt_q, 1'b0};
      sa  = a_q[idx +: 2];
      sb  = b_q[idx +: 2];
      s0  = sa[0] ^ sb[0] ^ c_q;
      c0  = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & c_q);
      // Upper bit is precomputed for both carries; the low-bit carry picks one.
      s1  = c0 ? ~(sa[1] ^ sb[1]) : (sa[1] ^ sb[1]);
      sc  = c0 ? (sa[1] | sb[1])  : (sa[1] & sb[1]);

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_d     = c_q;
      cout_d  = cout_q;
      id_d    = id_q;
      last_d  = last_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               a_d     = grant ? req1_a   : req0_a;
               b_d     = grant ? req1_b   : req0_b;
               c_d     = grant ? req1_cin : req0_cin;
               id_d    = grant;
               last_d  = grant;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx +: 2] = {s1, s0};
            c_d   = sc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cout_d  = sc;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         c_q        <= 1'b0;
         cout_q     <= 1'b0;
         id_q       <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         rst_seen_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         c_q        <= c_d;
         cout_q     <= cout_d;
         id_q       <= id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         rst_seen_q <= 1'b0;
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_csel_add_arbiter.sv
// tb/tb_csel_add_arbiter.sv - directed self-checking bench for csel_add_arbiter
// Inputs are driven and outputs sampled on the falling edge.
module tb_csel_add_arbiter;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req0_cin;
   logic [W-1:0]  req0_a, req0_b;
   logic          req1_valid, req1_ready, req1_cin;
   logic [W-1:0]  req1_a, req1_b;
   logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
   logic [W-1:0]  rsp_sum;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csel_add_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
   );

   task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents one request and returns at the falling edge after its handshake.
   task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int w;
      if (id == 0) begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
      end
      #1;
      w = 0;
      while (!((id == 0) ? req0_ready : req1_ready) && w < 100) begin
         @(negedge clk); #1; w++;
      end
      check("req_grant", (id == 0) ? req0_ready : req1_ready, 1);
      hs_cyc = cyc;
      @(negedge clk);
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      #1;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(negedge clk); #1; lat++;
      end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 0);
   endtask

   task automatic check_rsp(input string tag, input int id, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin);
      logic [W:0] exp;
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      check({tag, "_valid"}, rsp_valid, 1);
      check({tag, "_sum"}, {rsp_cout, rsp_sum}, exp);
      check({tag, "_id"}, rsp_id, id);
   endtask

   initial begin
      int lat;
      int prev_cyc;
      logic [W-1:0] ra, rb, held_sum;
      logic rc;

      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

      // Reset with both requesters already asserting; tie arbitration follows.
      req0_a = 64'd100; req0_b = 64'd23;
      req1_a = 64'd1000; req1_b = 64'd1; req1_cin = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0; #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_sum", {rsp_cout, rsp_sum}, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      @(negedge clk); #1;
      check("tie_first_r0", req0_ready, 1);
      check("tie_first_r1", req1_ready, 0);
      prev_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_rsp(lat);
         if (i % 2 == 0) check_rsp("tie", 0, 64'd100, 64'd23, 1'b0);
         else            check_rsp("tie", 1, 64'd1000, 64'd1, 1'b1);
         if (i > 0) check("tie_spacing", cyc - prev_cyc, 34);
         prev_cyc = cyc;
         @(negedge clk);
         if (i == 3) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         #1;
         check("tie_drop", rsp_valid, 0);
      end
      rsp_ready = 1'b0;

      // All-ones plus one: full carry ripple, latency check.
      issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait_rsp(lat);
      check("lat_ones", lat, 33);
      check_rsp("ones", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check("ones_exact", {rsp_cout, rsp_sum}, {1'b1, 64'd0});
      take_rsp();

      issue(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
      wait_rsp(lat);
      check("lat_cin", lat, 33);
      check("cin_exact", {rsp_cout, rsp_sum}, {1'b1, 64'd0});
      check("cin_id", rsp_id, 1);
      take_rsp();

      // Backpressure: ten cycles of rsp_ready low with both requesters pushing.
      issue(0, 64'h0000_0000_DEAD_BEEF, 64'h1234_0000_0000_0001, 1'b1);
      wait_rsp(lat);
      held_sum = rsp_sum;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("bp_valid", rsp_valid, 1);
         check("bp_sum", rsp_sum, held_sum);
         check("bp_ready0", req0_ready, 0);
         check("bp_ready1", req1_ready, 0);
      end
      check_rsp("bp", 0, 64'h0000_0000_DEAD_BEEF, 64'h1234_0000_0000_0001, 1'b1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      take_rsp();

      // Reset in the middle of RUN (slice 10) discards the transaction.
      issue(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b1; #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_sum", {rsp_cout, rsp_sum}, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_ready0", req0_ready, 0);
      issue(0, 64'd5, 64'd7, 1'b0);
      wait_rsp(lat);
      check("lat_after_rst", lat, 33);
      check("after_rst_sum", {rsp_cout, rsp_sum}, 65'd12);
      check("after_rst_id", rsp_id, 0);
      take_rsp();

      // One requester, back-to-back adds.
      prev_cyc = 0;
      for (int i = 0; i < 3; i++) begin
         issue(1, 64'd10 * (i + 1), 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
         if (i > 0) check("rep_spacing", hs_cyc - prev_cyc, 34);
         prev_cyc = hs_cyc;
         wait_rsp(lat);
         check_rsp("rep", 1, 64'd10 * (i + 1), 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
         take_rsp();
      end

      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom);
         issue(i % 2, ra, rb, rc);
         wait_rsp(lat);
         check_rsp("rand", i % 2, ra, rb, rc);
         take_rsp();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csel_add_arbiter.md
# csel_add_arbiter

Shared multi-cycle adder engine with two-requester round-robin arbitration. Accepts one WIDTH-bit add per transaction from either of two requesters over valid/ready. Sequences a single 2-bit carry-select slice (bit 0 by full adder; bit 1 precomputed for carry 0 and 1, then muxed) over WIDTH/2 cycles, rippling the carry through a register. Returns sum, carry-out and requester ID on a valid/ready response port. Used where area matters more than add latency; several low-rate clients share one narrow adder.

## Interface
- WIDTH, 64, operand width; must be even and at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as req0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_id  out  1  requester that issued the transaction.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, that requester wins. If both are high, the requester not in last_grant wins.
  - req{g}_ready = 1 only for the winner; the other ready = 0. With no valid, both readies = 0.
  - On handshake: latch a, b, cin and id = g; set last_grant = g; clear the slice counter; go to RUN.
- RUN: each cycle k (0..WIDTH/2-1):
  - Slice operand bits [2k+1:2k] with carry register c (c initialised to cin).
  - Bit 0 is a full adder. Bit 1 computes sum and carry for carry 0 and for carry 1, and the bit-0 carry selects between them.
  - Write the 2 sum bits into sum[2k+1:2k] and update c with the slice carry-out.
  - After slice WIDTH/2-1, set cout = c and go to DONE.
- DONE:
  - rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_id are stable until handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
- Both req readies are 0 in RUN and DONE. reqN_valid may change freely there with no effect.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin exactly, computed at WIDTH+1 bits.

## Timing
- Reset values: state = IDLE; req0_ready = req1_ready = 0 in the cycle after reset, then combinational as above; rsp_valid = 0; rsp_sum = 0; rsp_cout = 0; rsp_id = 0; last_grant = 1, so requester 0 wins the first tie; counter = 0; c = 0.
- Request handshake in cycle T: RUN occupies T+1 .. T+WIDTH/2; rsp_valid first high in cycle T+WIDTH/2+1. Latency is 32 cycles plus 1 at WIDTH = 64.
- Response handshake in cycle R: rsp_valid = 0 in R+1. The earliest next request handshake is R+1. There is no overlap of accept with a pending response.
- Throughput with rsp_ready held high: one transaction per WIDTH/2+2 cycles.
- Backpressure: rsp_ready = 0 holds DONE indefinitely with outputs unchanged.
- rst high in any state, including mid-RUN or DONE: the in-flight transaction is discarded with no response. Reset values apply from the next cycle.
- WIDTH = 2: RUN lasts exactly 1 cycle.

## Test plan
- Single add, WIDTH=64, req0: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, handshake at cycle T -> rsp_valid first at T+33; rsp_sum=0, rsp_cout=1, rsp_id=0.
- Carry-in propagation: req1, a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=1 -> rsp_sum=0, rsp_cout=1, rsp_id=1. Also run 1000 random operand/cin pairs; each matches the WIDTH+1-bit sum.
- Tie arbitration: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; each response carries the matching id and sum.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and data stable throughout, both readies 0. Release -> single handshake, IDLE next cycle.
- Reset mid-RUN: assert rst at slice 10 -> next cycle rsp_valid=0 and outputs 0. A subsequent req0 add of 5+7 returns 12, cout 0, with no stale response.
- Single requester repeated: req1 alone, three back-to-back adds -> all granted to req1; spacing between request handshakes is 34 cycles.
